// File: rtl/serial_word_deser.sv
// serial_word_deser: LSB-first serial-to-parallel deserializer with framing check and FWFT output FIFO
module serial_word_deser #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_din,
    input  logic                        i_din_valid,
    output logic [DATA_WIDTH-1:0]       o_word,
    output logic                        o_word_valid,
    input  logic                        i_word_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_count,
    output logic                        o_frame_err,
    output logic                        o_overflow,
    output logic [7:0]                  o_err_cnt
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [0:0] S_SHIFT = 1'b0;
    localparam logic [0:0] S_HUNT = 1'b1;

    logic [0:0] state;
    logic [CW-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0] shreg, sh_next;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic shifting, last, push, pop, full, wr, bad;

    assign shifting = i_en && state == S_SHIFT;
    assign last = bit_cnt == LAST;
    assign push = shifting && i_din_valid && last;
    assign bad = shifting && (i_din_valid != last);
    assign full = o_count == FULL;
    assign pop = o_word_valid && i_word_ready;
    assign wr = push && (!full || pop);
    assign o_word_valid = o_count != '0;
    assign o_word = o_word_valid ? mem[rd_ptr] : '0;

    // current shift register with the incoming bit merged in; this is also the word pushed on a good marker
    always_comb begin
        sh_next = shreg;
        sh_next[bit_cnt] = i_din;
    end

    // framing FSM: assemble bits in S_SHIFT, skip bits in S_HUNT until a marker resynchronises
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_SHIFT;
            bit_cnt <= '0;
            shreg <= '0;
        end else if (i_en) begin
            if (state == S_HUNT) begin
                state <= i_din_valid ? S_SHIFT : S_HUNT;
                bit_cnt <= '0;
            end else begin
                shreg <= sh_next;
                bit_cnt <= (i_din_valid || last) ? '0 : bit_cnt + CW'(1);
                state <= (!i_din_valid && last) ? S_HUNT : S_SHIFT;
            end
        end
    end

    // FIFO storage, written only when the word is actually accepted
    always_ff @(posedge i_clk) begin
        if (wr)
            mem[wr_ptr] <= sh_next;
    end

    // FIFO pointers and occupancy; a push into a full FIFO succeeds only if a pop frees a slot the same cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_count <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            o_count <= o_count + (AW + 1)'(wr) - (AW + 1)'(pop);
            o_overflow <= push && full && !pop;
        end
    end

    // framing error pulse and its saturating counter
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_frame_err <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_frame_err <= bad;
            if (bad && o_err_cnt != 8'hFF)
                o_err_cnt <= o_err_cnt + 8'd1;
        end
    end
endmodule
